// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and field layout for pipe_stage_buf
package pipe_pkg;

  // Holding state of a stage buffer; the encoding equals the number of held beats
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_DATA_W = 224;

  // Control vector bit positions
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_JAL       = 4;
  localparam int CTRL_ECALL     = 5;
  localparam int CTRL_AES_EN    = 6;
  localparam int CTRL_AES_DEC   = 7;

  // Data vector field offsets, 32 bits each
  localparam int DATA_PC       = 0;
  localparam int DATA_PC_PLUS4 = 32;
  localparam int DATA_PC_IMM   = 64;
  localparam int DATA_RESULT   = 96;
  localparam int DATA_RD2      = 128;
  localparam int DATA_U_TYPE   = 160;
  localparam int DATA_W3       = 192;

endpackage

// File: rtl/pipe_stage_entry.sv
// rtl/pipe_stage_entry.sv - one ctrl+data holding register with valid, load/clear/hold
module pipe_stage_entry
  import pipe_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Clear wins over load so an invalid entry never keeps stale control bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage register with back-pressure, skid, flush, freeze; perf counters under PIPE_STAGE_BUF_PERF_EN
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W  = PIPE_CTRL_W,
  parameter int DATA_W  = PIPE_DATA_W,
  parameter bit SKID_EN = 1'b1
`ifdef PIPE_STAGE_BUF_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_STAGE_BUF_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
`endif
);

  pipe_state_e       state, state_next;
  logic              ready_q;
  logic              push, pop;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  // ready_q is low while reset is held and for the first cycle after release;
  // with a skid it also carries the registered "not full" status
  assign in_ready  = SKID_EN ? (start & ready_q)
                             : (start & ready_q & (~main_valid | out_ready));
  assign out_valid = start & main_valid;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_data  = out_valid ? main_data : '0;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

  // Entry controls and next state; freeze needs no term since push/pop are already gated by start
  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            main_load  = 1'b1;
            state_next = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            skid_load  = 1'b1;
            state_next = TWO;
          end else if (pop) begin
            main_clear = 1'b1;
            state_next = EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Holding-state register plus registered input-ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
    end else begin
      state   <= state_next;
      ready_q <= SKID_EN ? (state_next != TWO) : 1'b1;
    end
  end

  pipe_stage_entry #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .load_ctrl (main_from_skid ? skid_ctrl : in_ctrl),
    .load_data (main_from_skid ? skid_data : in_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  if (SKID_EN) begin : g_skid
    pipe_stage_entry #(
      .CTRL_W (CTRL_W),
      .DATA_W (DATA_W)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .load      (skid_load),
      .clear     (skid_clear),
      .load_ctrl (in_ctrl),
      .load_data (in_data),
      .valid     (skid_valid),
      .ctrl      (skid_ctrl),
      .data      (skid_data)
    );
  end else begin : g_no_skid
    logic unused_skid_ctl;
    assign unused_skid_ctl = skid_load | skid_clear;
    assign skid_valid = 1'b0;
    assign skid_ctrl  = '0;
    assign skid_data  = '0;
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  // Saturating stall and bubble counters; only reset clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (start && !out_valid && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - bench for pipe_stage_buf, skid and single-entry builds side by side
module tb_pipe_stage_buf;

  typedef struct packed {
    logic [15:0]  c;
    logic [223:0] d;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset, start, flush, in_valid, out_ready;
  logic [15:0]  in_ctrl;
  logic [223:0] in_data;
  logic         rdy [2];
  logic         ov  [2];
  logic [15:0]  oc  [2];
  logic [223:0] od  [2];
  logic [1:0]   occ [2];
`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0]  stall [2];
  logic [31:0]  bubble [2];
`endif

  int checks = 0;
  int failures = 0;

  beat_t mq [2][$];
  bit    live [2];
  bit    m_er, m_ev, m_pu, m_po;
  beat_t m_head, m_in;

  logic [223:0] pat_a5;
  int           nxt [2];

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(16), .DATA_W(224), .SKID_EN(1'b1)) u_skid (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[0]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_ctrl(oc[0]), .out_data(od[0]),
    .occupancy(occ[0])
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(stall[0]), .bubble_cnt(bubble[0])
`endif
  );

  pipe_stage_buf #(.CTRL_W(16), .DATA_W(224), .SKID_EN(1'b0)) u_single (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy[1]), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_ctrl(oc[1]), .out_data(od[1]),
    .occupancy(occ[1])
`ifdef PIPE_STAGE_BUF_PERF_EN
    , .stall_cnt(stall[1]), .bubble_cnt(bubble[1])
`endif
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue model: capacity 2 with registered ready, or capacity 1 that accepts while draining
  function automatic bit exp_ready(int m);
    if (!live[m] || !start) return 1'b0;
    if (m == 0) return mq[0].size() < 2;
    return (mq[1].size() == 0) || out_ready;
  endfunction

  // Compare every cycle, then advance the model by the coming edge
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (!reset) begin
        mq[m].delete();
        live[m] = 1'b0;
        chk($sformatf("m%0d_rst_ready", m), rdy[m], 0);
        chk($sformatf("m%0d_rst_valid", m), ov[m], 0);
        chk($sformatf("m%0d_rst_ctrl", m), oc[m], 0);
        chk($sformatf("m%0d_rst_data", m), od[m], 0);
        chk($sformatf("m%0d_rst_occ", m), occ[m], 0);
      end else begin
        m_er   = exp_ready(m);
        m_ev   = start && (mq[m].size() > 0);
        m_head = m_ev ? mq[m][0] : '0;
        chk($sformatf("m%0d_in_ready", m), rdy[m], m_er);
        chk($sformatf("m%0d_out_valid", m), ov[m], m_ev);
        chk($sformatf("m%0d_out_ctrl", m), oc[m], m_head.c);
        chk($sformatf("m%0d_out_data", m), od[m], m_head.d);
        chk($sformatf("m%0d_occupancy", m), occ[m], mq[m].size());
        m_pu = in_valid && m_er;
        m_po = m_ev && out_ready;
        m_in = {in_ctrl, in_data};
        if (flush) mq[m].delete();
        else begin
          if (m_po) void'(mq[m].pop_front());
          if (m_pu) mq[m].push_back(m_in);
        end
        live[m] = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    pat_a5    = {28{8'hA5}};
    reset     = 1'b0;
    start     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    repeat (2) step();
    reset = 1'b1;
    step();

    // single beat, one-cycle latency
    in_valid = 1'b1; in_ctrl = 16'h0001; in_data = pat_a5; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("d1_valid", ov[0], 1);
    chk("d1_ctrl", oc[0], 16'h0001);
    chk("d1_data", od[0], pat_a5);
    chk("d1_occ1", occ[0], 1);
    step();
    @(negedge clk);
    chk("d1_occ0", occ[0], 0);

`ifdef PIPE_STAGE_BUF_PERF_EN
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0077;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    chk("perf_stall_skid", stall[0], 5);
    chk("perf_stall_single", stall[1], 5);
    out_ready = 1'b1;
    step();
`endif

    // fill the skid, then drain
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0011;
    step();
    in_ctrl = 16'h0022;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("d2_occ2", occ[0], 2);
    chk("d2_ready0", rdy[0], 0);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("d2_first", oc[0], 16'h0011);
    step();
    @(negedge clk);
    chk("d2_second", oc[0], 16'h0022);
    step();
    @(negedge clk);
    chk("d2_empty", ov[0], 0);

    // flush while full with a beat offered
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0055;
    step();
    in_ctrl = 16'h0066;
    step();
    flush = 1'b1; in_ctrl = 16'h0033;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("d3_occ", occ[0], 0);
    chk("d3_ctrl", oc[0], 0);
    chk("d3_data", od[0], 0);
    step();
    out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("d3_no_ghost", ov[0], 0);

    // freeze with one held beat
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0044; in_data = pat_a5;
    step();
    in_valid = 1'b0; start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("d4_frz_valid", ov[0], 0);
      chk("d4_frz_ctrl", oc[0], 0);
      chk("d4_frz_ready", rdy[0], 0);
      step();
    end
    start = 1'b1;
    @(negedge clk);
    chk("d4_resume_valid", ov[0], 1);
    chk("d4_resume_ctrl", oc[0], 16'h0044);
    step();
    out_ready = 1'b1;
    repeat (2) step();

    // 100 back-to-back beats, both variants
    nxt[0] = 1; nxt[1] = 1;
    for (int i = 1; i <= 101; i++) begin
      in_valid = (i <= 100);
      in_ctrl  = 16'(i);
      in_data  = {7{i}};
      @(negedge clk);
      for (int m = 0; m < 2; m++)
        if (ov[m] && oc[m] == 16'(nxt[m])) nxt[m]++;
      step();
    end
    in_valid = 1'b0;
    chk("d5_skid_count", nxt[0] - 1, 100);
    chk("d5_single_count", nxt[1] - 1, 100);

    // random traffic against the model
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom % 4) != 0;
      in_ctrl   = 16'($urandom);
      for (int w = 0; w < 7; w++) in_data[w*32 +: 32] = $urandom;
      out_ready = ($urandom % 3) != 0;
      start     = ($urandom % 16) != 0;
      flush     = ($urandom % 32) == 0;
      step();
    end

    // asynchronous reset mid-stream
    start = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 16'h0099;
    repeat (2) step();
    #2;
    reset = 1'b0;
    #1;
    chk("ar_valid", ov[0], 0);
    chk("ar_occ", occ[0], 0);
    chk("ar_ready", rdy[0], 0);
    chk("ar_ctrl", oc[0], 0);
    chk("ar_occ_single", occ[1], 0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("ar_stall", stall[0], 0);
    chk("ar_bubble", bubble[0], 0);
`endif
    step();
    reset = 1'b1; in_valid = 1'b0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised inter-stage pipeline register for the RV32I core (ID/EX, EX/MEM, MEM/WB); next generation of the fixed per-signal stage registers.
- Carries one packed control vector and one packed data vector per beat.
- Adds valid/ready back-pressure with an optional 2-entry skid, synchronous flush, and start-gated freeze.
- Bubbles always present all-zero control, i.e. a NOP to the downstream stage.

Parameters:
- CTRL_W, 16, width of packed control bits (reg_write, mem_read, mem_write, branch, jal, ecall, AES flags, ...).
- DATA_W, 224, width of packed data (pc, pc_plus4, pc_imm, result, rd2, u_type, w3).
- SKID_EN, 1, 1 = two-entry skid with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run enable; 0 freezes the stage.
- flush  in  1  synchronous kill of all held beats (branch/jump redirect).
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream data.
- out_valid  out  1  head beat valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control; 0 when out_valid=0.
- out_data  out  DATA_W  head data; 0 when out_valid=0.
- occupancy  out  2  number of held beats (0..2).

Behaviour:
- Handshake definitions: push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage: main entry (head) and skid entry, each with a valid bit. out_* are driven from main.
- Reset (reset=0, asynchronous): both entries invalid with ctrl/data = 0; occupancy=0; out_valid=0; in_ready=0 while reset is held.
- Priority order: reset > flush > start=0 > normal operation.
- FSM when SKID_EN=1 (states EMPTY / ONE / TWO):
  - EMPTY: push -> ONE, main<=in.
  - ONE: push&~pop -> TWO, skid<=in. pop&~push -> EMPTY, main cleared to 0. push&pop -> ONE, main<=in.
  - TWO: pop -> ONE, main<=skid, skid cleared. No push is possible in TWO.
  - in_ready is registered: 1 in EMPTY and ONE, 0 in TWO, and 0 when start=0.
- SKID_EN=0 (single entry, states EMPTY / ONE):
  - in_ready = start & (~main_valid | out_ready), combinational.
  - push&pop in ONE replaces main in the same cycle.
- Latency: one cycle from push to out_valid. Full throughput of 1 beat/cycle when out_ready stays high.
- flush=1: on the next edge, all entries are invalidated and zeroed and the state goes to EMPTY. A push in the same cycle is dropped. A pop in the same cycle still completes downstream. in_ready is unaffected by flush.
- start=0:
  - Contents are held and the state is frozen.
  - out_valid=0 and out_ctrl/out_data=0, so no pop occurs.
  - in_ready=0.
  - When start returns to 1, the held beats reappear unchanged.
- Zeroing: any invalid entry holds all-zero ctrl/data, so no stale reg_write or mem_write can leak downstream.
- No overflow or underflow is possible: push is gated by in_ready, and pop by out_valid.

Optional Feature:
- Macro: PIPE_STAGE_BUF_PERF_EN.
- Defined: adds outputs stall_cnt[CNT_W] and bubble_cnt[CNT_W], both reset to 0, both saturating at all-ones.
  - stall_cnt increments every cycle with out_valid & ~out_ready.
  - bubble_cnt increments every cycle with start & ~out_valid.
  - flush does not clear either counter.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - the state enum {EMPTY, ONE, TWO};
  - the CTRL bit-index localparams (CTRL_REG_WRITE, CTRL_MEM_READ, CTRL_MEM_WRITE, CTRL_BRANCH, CTRL_JAL, CTRL_ECALL, ...);
  - DATA field offsets.
- One sub-module, pipe_stage_entry: a ctrl+data register with valid, supporting load, clear (zero) and hold. It is instantiated twice, once for main and once for skid; skid is omitted when SKID_EN=0.

Test Plan:
- Reset deassert, then push ctrl=0x0001 data=0xA5..A5 with out_ready=1 -> out_valid=1 on the next cycle with identical values; occupancy 1, then 0.
- SKID_EN=1, out_ready=0, push beats 0x11 and 0x22 -> occupancy=2, in_ready=0. Raise out_ready -> out_ctrl shows 0x11 then 0x22 in consecutive cycles, no loss.
- Occupancy 2, flush=1 with in_valid=1 and ctrl=0x33 -> next cycle occupancy=0, out_ctrl=0, out_data=0; beat 0x33 never appears.
- Occupancy 1 holding 0x44, start=0 for 3 cycles -> out_valid=0, outputs zero, in_ready=0. start=1 -> 0x44 emerges intact.
- Continuous push of 1..100 with out_ready=1 -> 100 beats out in order, 1 per cycle. Repeat with SKID_EN=0, same result.
- PIPE_STAGE_BUF_PERF_EN defined: hold out_ready=0 for 5 cycles with occupancy=1 -> stall_cnt=5. Assert reset=0 mid-stream -> all outputs and counters become 0 immediately, without waiting for a clock edge.
